// File: rtl/score_uart_tx_pkg.sv
// Shared constants and types for the score status-line transmitter.
// SCORE_TX_CHECKSUM_EN lengthens the line by two hex checksum characters.
package score_uart_tx_pkg;

  localparam logic [7:0] ASCII_S      = 8'h53;
  localparam logic [7:0] ASCII_COLON  = 8'h3A;
  localparam logic [7:0] ASCII_DASH   = 8'h2D;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT0 = 8'h30;

  localparam int MSG_LEN_PLAIN = 9;
  localparam int MSG_LEN_CSUM  = 11;
`ifdef SCORE_TX_CHECKSUM_EN
  localparam int MSG_LEN = MSG_LEN_CSUM;
`else
  localparam int MSG_LEN = MSG_LEN_PLAIN;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_FINISH
  } state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_DIGIT0 + {4'h0, d};
  endfunction

`ifdef SCORE_TX_CHECKSUM_EN
  // Uppercase hex: 'A' is 8'h41, so 10..15 map through 8'h37 + n.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_DIGIT0 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

endpackage

// File: rtl/score_uart_tx_bin2dec_2digit.sv
// Two-digit binary-to-decimal converter by repeated subtraction of 10.
// start loads a new value (0..99); en steps one subtraction per cycle until done.
module score_uart_tx_bin2dec_2digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  input  logic [6:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      tens <= '0;
    end else if (start) begin
      rem  <= value;
      tens <= '0;
    end else if (en && !done) begin
      rem  <= rem - 7'd10;
      tens <= tens + 4'd1;
    end
  end

  assign done = (rem < 7'd10);
  assign ones = rem[3:0];

endmodule

// File: rtl/score_uart_tx.sv
// Snapshots both paddle scores and streams "S:LL-RR\r\n" to UART_TX, one byte per handshake.
// SCORE_TX_CHECKSUM_EN inserts two hex chars (XOR of bytes 0..6) before CR.
module score_uart_tx
  import score_uart_tx_pkg::*;
#(
  parameter int SCORE_WIDTH = 7
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Report,
  input  logic [SCORE_WIDTH-1:0] i_Score_Left,
  input  logic [SCORE_WIDTH-1:0] i_Score_Right,
  input  logic                   i_TX_Done,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  output logic                   o_Busy,
  output logic                   o_Msg_Done
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_t          state;
  logic            pending;
  logic [3:0]      idx;
  logic            capture;
  logic [1:0][6:0] score_sat;
  logic [1:0][3:0] tens;
  logic [1:0][3:0] ones;
  logic [1:0]      cvt_done;
  logic [7:0]      msg_byte;

  function automatic logic [6:0] sat99(input logic [SCORE_WIDTH-1:0] v);
    return (32'(v) > 32'd99) ? 7'd99 : 7'(v);
  endfunction

  assign score_sat[0] = sat99(i_Score_Left);
  assign score_sat[1] = sat99(i_Score_Right);

  // Snapshot happens on a fresh request in IDLE or on a queued/coincident one in FINISH.
  assign capture = ((state == ST_IDLE) && i_Report) ||
                   ((state == ST_FINISH) && (pending || i_Report));

  generate
    for (genvar g = 0; g < 2; g++) begin : g_cvt
      score_uart_tx_bin2dec_2digit u_cvt (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .start (capture),
        .en    (state == ST_CONVERT),
        .value (score_sat[g]),
        .done  (cvt_done[g]),
        .tens  (tens[g]),
        .ones  (ones[g])
      );
    end
  endgenerate

`ifdef SCORE_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = ASCII_S ^ ASCII_COLON ^ digit_char(tens[0]) ^ digit_char(ones[0]) ^
                ASCII_DASH ^ digit_char(tens[1]) ^ digit_char(ones[1]);
`endif

  always_comb begin
    msg_byte = 8'h00;
    case (idx)
      4'd0: msg_byte = ASCII_S;
      4'd1: msg_byte = ASCII_COLON;
      4'd2: msg_byte = digit_char(tens[0]);
      4'd3: msg_byte = digit_char(ones[0]);
      4'd4: msg_byte = ASCII_DASH;
      4'd5: msg_byte = digit_char(tens[1]);
      4'd6: msg_byte = digit_char(ones[1]);
`ifdef SCORE_TX_CHECKSUM_EN
      4'd7:  msg_byte = hex_char(csum[7:4]);
      4'd8:  msg_byte = hex_char(csum[3:0]);
      4'd9:  msg_byte = ASCII_CR;
      4'd10: msg_byte = ASCII_LF;
`else
      4'd7: msg_byte = ASCII_CR;
      4'd8: msg_byte = ASCII_LF;
`endif
      default: msg_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      idx        <= '0;
      o_TX_DV    <= 1'b0;
      o_TX_Byte  <= 8'h00;
      o_Busy     <= 1'b0;
      o_Msg_Done <= 1'b0;
    end else begin
      o_TX_DV    <= 1'b0;
      o_Msg_Done <= 1'b0;
      if ((state != ST_IDLE) && i_Report) pending <= 1'b1;
      case (state)
        ST_IDLE: if (i_Report) begin
          o_Busy <= 1'b1;
          state  <= ST_CONVERT;
        end
        ST_CONVERT: if (&cvt_done) state <= ST_LOAD;
        ST_LOAD: begin
          o_TX_Byte <= msg_byte;
          o_TX_DV   <= 1'b1;
          state     <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (i_TX_Done) begin
          if (idx == LAST_IDX) begin
            state <= ST_FINISH;
          end else begin
            idx   <= idx + 4'd1;
            state <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          o_Msg_Done <= 1'b1;
          idx        <= '0;
          // A request coincident with FINISH merges into pending (overrides the set above).
          if (pending || i_Report) begin
            pending <= 1'b0;
            state   <= ST_CONVERT;
          end else begin
            o_Busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
